// File: rtl/dbg_mem_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the debug memory arbiter.
package dbg_arb_pkg;

    localparam int unsigned MAX_PORTS = 32;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // Offsets are walked downwards so the requester closest to ptr overwrites the rest.
    function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                            input int unsigned          ptr,
                                            input int unsigned          n);
        int unsigned idx;
        int unsigned off;
        rr_pick = ptr;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            off = MAX_PORTS - 1 - i;
            if (off < n) begin
                idx = ptr + off;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/dbg_mem_arbiter_if.sv
// req/gnt/rvalid memory bus bundle, N lanes wide; rdata is shared by all lanes.
interface dbg_mem_arbiter_if #(
    parameter int unsigned N          = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [N-1:0]                    req;
    logic [N-1:0][ADDR_WIDTH-1:0]    addr;
    logic [N-1:0]                    we;
    logic [N-1:0][DATA_WIDTH-1:0]    wdata;
    logic [N-1:0][DATA_WIDTH/8-1:0]  be;
    logic [N-1:0]                    gnt;
    logic [N-1:0]                    rvalid;
    logic [DATA_WIDTH-1:0]           rdata;

    modport master (
        output req, addr, we, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dbg_mem_arbiter_owner_fifo.sv
// In-order FIFO of requester indices, one entry per granted-but-unanswered transaction.
module dbg_arb_owner_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end
endmodule

// File: rtl/dbg_mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid master port among NR_PORTS requesters,
// with the winner locked until the downstream grant and responses routed by an owner FIFO.
module dbg_mem_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int unsigned NR_PORTS        = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dbg_mem_arbiter_if.slave   slv,
    dbg_mem_arbiter_if.master  mst,
    output logic               busy,
    output logic               err
);
    localparam int unsigned IW = $clog2(NR_PORTS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] lock_q, lock_d;
    logic          err_q, err_d;
    logic [IW-1:0] pick;
    logic [IW-1:0] winner;
    logic [IW-1:0] head;
    logic          mst_req;
    logic          handshake;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count;

    assign pick      = IW'(rr_pick(MAX_PORTS'(slv.req), 32'(rr_q), NR_PORTS));
    assign handshake = mst_req & mst.gnt[0];
    assign pop       = mst.rvalid[0] & ~fifo_empty;

    // The full check uses the registered count, so a same-cycle response does not unblock.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        winner  = lock_q;
        mst_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((|slv.req) && !fifo_full) begin
                    mst_req = 1'b1;
                    winner  = pick;
                    if (!mst.gnt[0]) begin
                        state_d = LOCKED;
                        lock_d  = pick;
                    end
                end
            end
            LOCKED: begin
                mst_req = 1'b1;
                winner  = lock_q;
                if (mst.gnt[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (handshake) begin
            rr_d = (winner == IW'(NR_PORTS - 1)) ? '0 : winner + 1'b1;
        end
        err_d = err_q | (mst.rvalid[0] & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    dbg_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW)
    ) u_owner_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        slv.gnt    = '0;
        slv.rvalid = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            slv.gnt[i]    = handshake && (winner == IW'(i));
            slv.rvalid[i] = pop && (head == IW'(i));
        end
    end

    // Request fields are zeroed when idle so nothing leaks downstream without mst_req.
    assign mst.req[0]   = mst_req;
    assign mst.addr[0]  = mst_req ? slv.addr[winner]  : '0;
    assign mst.we[0]    = mst_req ? slv.we[winner]    : 1'b0;
    assign mst.wdata[0] = mst_req ? slv.wdata[winner] : '0;
    assign mst.be[0]    = mst_req ? slv.be[winner]    : '0;
    assign slv.rdata    = mst.rdata;

    assign busy = (count != '0) | mst_req;
    assign err  = err_q;
endmodule
